hazard_sequencer: RTL and testbench

- Pipeline control block for the fetch/decode front end.
- Watches the decoded ID-stage fields (opcode, rs, rt) against in-flight EX/MEM destinations and resolved branch/jump events.
- Drives the PC write enable, the IF/ID (decode) write enable and the flush strobes.
- Sequences multi-cycle load-use stalls and control-flow flushes.
- Keeps a saturating stall/flush statistics counter.

---
 rtl/isa_pkg.sv | 31 +++
 rtl/sat_counter.sv | 20 ++
 rtl/hazard_sequencer.sv | 147 ++++++++++++++
 tb/tb_hazard_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - shared opcode constants, sequencer state encoding and operand-use helpers
package isa_pkg;

    localparam logic [5:0] OP_R   = 6'h03;
    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_JAL = 6'h07;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] OP_LW  = 6'h23;

    // Wide enough for LOAD_LAT up to 7 and FLUSH_CYC up to 3
    localparam int SEQ_CNT_W = 3;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } seq_state_t;

    // Jumps carry only an immediate target, every other opcode reads rs
    function automatic logic uses_rs(input logic [5:0] op);
        return !(op == OP_J || op == OP_JAL);
    endfunction

    // rt is a source only for register-register ops, stores and compares
    function automatic logic uses_rt(input logic [5:0] op);
        return (op == OP_R) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with async active-high reset
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up on inc, stick at all-ones instead of wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_sequencer.sv
// rtl/hazard_sequencer.sv - load-use stall and control-flow flush sequencer for the front end
module hazard_sequencer
    import isa_pkg::*;
#(
    parameter int LOAD_LAT  = 1,
    parameter int FLUSH_CYC = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [5:0]       id_opcode,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_dest,
    input  logic             ex_branch_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [SEQ_CNT_W-1:0] LOAD_RELOAD  = SEQ_CNT_W'(LOAD_LAT - 1);
    localparam logic [SEQ_CNT_W-1:0] FLUSH_RELOAD = SEQ_CNT_W'(FLUSH_CYC - 1);

    seq_state_t           state, state_nx;
    logic [SEQ_CNT_W-1:0] cnt, cnt_nx;
    logic                 hazard, jump_id, branch_flush;

    // Decode-stage hazard and jump detection; register 0 is never a real producer
    always_comb begin
        hazard  = id_valid && ex_mem_read && (ex_dest != 5'd0) &&
                  ((uses_rs(id_opcode) && (ex_dest == id_rs)) ||
                   (uses_rt(id_opcode) && (ex_dest == id_rt)));
        jump_id = id_valid && ((id_opcode == OP_J) || (id_opcode == OP_JAL));
    end

    // State and remaining-cycle register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next state and pipeline controls; a taken branch overrides everything
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        branch_flush = 1'b0;
        case (state)
            ST_RUN: begin
                if (ex_branch_taken) begin
                    ifid_flush   = 1'b1;
                    idex_flush   = 1'b1;
                    branch_flush = 1'b1;
                    if (FLUSH_CYC > 1) begin
                        state_nx = ST_FLUSH;
                        cnt_nx   = FLUSH_RELOAD;
                    end
                end else if (hazard) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                    if (LOAD_LAT > 1) begin
                        state_nx = ST_STALL;
                        cnt_nx   = LOAD_RELOAD;
                    end
                end else if (jump_id) begin
                    ifid_flush = 1'b1;
                end
            end
            ST_STALL: begin
                if (ex_branch_taken) begin
                    ifid_flush   = 1'b1;
                    idex_flush   = 1'b1;
                    branch_flush = 1'b1;
                    if (FLUSH_CYC > 1) begin
                        state_nx = ST_FLUSH;
                        cnt_nx   = FLUSH_RELOAD;
                    end else begin
                        state_nx = ST_RUN;
                        cnt_nx   = '0;
                    end
                end else begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                    if (cnt <= SEQ_CNT_W'(1)) begin
                        state_nx = ST_RUN;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt - SEQ_CNT_W'(1);
                    end
                end
            end
            ST_FLUSH: begin
                ifid_flush   = 1'b1;
                idex_flush   = 1'b1;
                branch_flush = 1'b1;
                if (ex_branch_taken) begin
                    cnt_nx = FLUSH_RELOAD;
                end else if (cnt <= SEQ_CNT_W'(1)) begin
                    state_nx = ST_RUN;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt - SEQ_CNT_W'(1);
                end
            end
            default: begin
                state_nx = ST_RUN;
                cnt_nx   = '0;
            end
        endcase
    end

    // Busy whenever a multi-cycle sequence is in progress
    always_comb begin
        busy = (state != ST_RUN);
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (!pc_write),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (branch_flush),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_sequencer.sv
// tb/tb_hazard_sequencer.sv - self-checking bench for hazard_sequencer against a behavioural model
module tb_hazard_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [5:0] id_opcode;
    logic [4:0] id_rs, id_rt;
    logic       ex_mem_read;
    logic [4:0] ex_dest;
    logic       ex_branch_taken;

    logic        a_pc, a_ifw, a_iff, a_idf, a_busy;
    logic [15:0] a_sc, a_fc;
    logic        b_pc, b_ifw, b_iff, b_idf, b_busy;
    logic [3:0]  b_sc, b_fc;

    int n_tests = 0;
    int n_fail  = 0;

    // Model parameters for the two instances
    int LL[2]   = '{1, 3};
    int FC[2]   = '{1, 2};
    int CMAX[2] = '{65535, 15};

    int   m_stall[2], m_flush[2], m_sc[2], m_fc[2];
    logic e_pc[2], e_ifw[2], e_iff[2], e_idf[2], e_bf[2], e_busy[2];
    logic m_hz, m_jp;

    always #5 clk = ~clk;

    hazard_sequencer #(.LOAD_LAT(1), .FLUSH_CYC(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs(id_rs), .id_rt(id_rt), .ex_mem_read(ex_mem_read), .ex_dest(ex_dest),
        .ex_branch_taken(ex_branch_taken), .pc_write(a_pc), .ifid_write(a_ifw),
        .ifid_flush(a_iff), .idex_flush(a_idf), .busy(a_busy),
        .stall_cnt(a_sc), .flush_cnt(a_fc)
    );

    hazard_sequencer #(.LOAD_LAT(3), .FLUSH_CYC(2), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs(id_rs), .id_rt(id_rt), .ex_mem_read(ex_mem_read), .ex_dest(ex_dest),
        .ex_branch_taken(ex_branch_taken), .pc_write(b_pc), .ifid_write(b_ifw),
        .ifid_flush(b_iff), .idex_flush(b_idf), .busy(b_busy),
        .stall_cnt(b_sc), .flush_cnt(b_fc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_stall[i] = 0; m_flush[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
        end
    endfunction

    // Expected controls from the remaining bubble/flush cycle counts and the current inputs
    function automatic void model_eval();
        logic rs_used, rt_used;
        rs_used = !(id_opcode == 6'h02 || id_opcode == 6'h07);
        rt_used = (id_opcode == 6'h03) || (id_opcode == 6'h2B) ||
                  (id_opcode == 6'h04) || (id_opcode == 6'h05);
        m_hz = id_valid && ex_mem_read && (ex_dest != 0) &&
               ((rs_used && ex_dest == id_rs) || (rt_used && ex_dest == id_rt));
        m_jp = id_valid && (id_opcode == 6'h02 || id_opcode == 6'h07);
        for (int i = 0; i < 2; i++) begin
            e_busy[i] = (m_stall[i] > 0) || (m_flush[i] > 0);
            e_pc[i] = 1; e_ifw[i] = 1; e_iff[i] = 0; e_idf[i] = 0; e_bf[i] = 0;
            if (ex_branch_taken || m_flush[i] > 0) begin
                e_iff[i] = 1; e_idf[i] = 1; e_bf[i] = 1;
            end else if (m_stall[i] > 0 || m_hz) begin
                e_pc[i] = 0; e_ifw[i] = 0; e_idf[i] = 1;
            end else if (m_jp) begin
                e_iff[i] = 1;
            end
        end
    endfunction

    function automatic void model_advance();
        for (int i = 0; i < 2; i++) begin
            if (!e_pc[i] && m_sc[i] < CMAX[i]) m_sc[i]++;
            if (e_bf[i]  && m_fc[i] < CMAX[i]) m_fc[i]++;
            if (ex_branch_taken) begin
                m_flush[i] = FC[i] - 1;
                m_stall[i] = 0;
            end else if (m_flush[i] > 0) begin
                m_flush[i]--;
            end else if (m_stall[i] > 0) begin
                m_stall[i]--;
            end else if (m_hz) begin
                m_stall[i] = LL[i] - 1;
            end
        end
    endfunction

    task automatic check_outputs();
        model_eval();
        check("a.pc_write",   32'(a_pc),   32'(e_pc[0]));
        check("a.ifid_write", 32'(a_ifw),  32'(e_ifw[0]));
        check("a.ifid_flush", 32'(a_iff),  32'(e_iff[0]));
        check("a.idex_flush", 32'(a_idf),  32'(e_idf[0]));
        check("a.busy",       32'(a_busy), 32'(e_busy[0]));
        check("a.stall_cnt",  32'(a_sc),   32'(m_sc[0]));
        check("a.flush_cnt",  32'(a_fc),   32'(m_fc[0]));
        check("b.pc_write",   32'(b_pc),   32'(e_pc[1]));
        check("b.ifid_write", 32'(b_ifw),  32'(e_ifw[1]));
        check("b.ifid_flush", 32'(b_iff),  32'(e_iff[1]));
        check("b.idex_flush", 32'(b_idf),  32'(e_idf[1]));
        check("b.busy",       32'(b_busy), 32'(e_busy[1]));
        check("b.stall_cnt",  32'(b_sc),   32'(m_sc[1]));
        check("b.flush_cnt",  32'(b_fc),   32'(m_fc[1]));
    endtask

    // One pipeline cycle: inputs already applied, check mid-cycle, then clock the model
    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rs,
                         input logic [4:0] rt, input logic mr, input logic [4:0] dst,
                         input logic br);
        id_valid = v; id_opcode = op; id_rs = rs; id_rt = rt;
        ex_mem_read = mr; ex_dest = dst; ex_branch_taken = br;
    endtask

    task automatic idle(input int n);
        drive(0, 6'h00, 0, 0, 0, 0, 0);
        for (int k = 0; k < n; k++) cycle();
    endtask

    logic [5:0] ops[8] = '{6'h03, 6'h02, 6'h07, 6'h04, 6'h05, 6'h2B, 6'h23, 6'h08};

    initial begin
        rst = 1'b1;
        drive(0, 6'h00, 0, 0, 0, 0, 0);
        model_reset();
        #2;
        check("rst.a.pc_write", 32'(a_pc), 32'd1);
        check("rst.b.busy",     32'(b_busy), 32'd0);
        check("rst.b.idex_flush", 32'(b_idf), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Load-use on rs
        drive(1, 6'h03, 5, 0, 1, 5, 0);
        cycle();
        idle(3);
        check("rs_hazard.a.stall_cnt", 32'(a_sc), 32'd1);
        check("rs_hazard.b.stall_cnt", 32'(b_sc), 32'd3);

        // rt used by SW, not by LW
        drive(1, 6'h2B, 1, 9, 1, 9, 0);
        cycle();
        idle(3);
        drive(1, 6'h23, 1, 9, 1, 9, 0);
        cycle();
        check("lw_rt.b.stall_cnt", 32'(b_sc), 32'd6);

        // Register zero
        drive(1, 6'h03, 0, 0, 1, 0, 0);
        cycle();
        check("r0.a.stall_cnt", 32'(a_sc), 32'd2);

        // Branch during second stall cycle
        drive(1, 6'h03, 7, 0, 1, 7, 0);
        cycle();
        drive(0, 6'h00, 0, 0, 0, 0, 1);
        cycle();
        idle(2);
        check("br_stall.b.flush_cnt", 32'(b_fc), 32'd2);

        // Jump in decode
        drive(1, 6'h02, 3, 3, 0, 0, 0);
        cycle();
        idle(1);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            drive(1'($urandom_range(0, 3) != 0), ops[$urandom_range(0, 7)],
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 7) == 0));
            cycle();
        end
        idle(4);

        // Asynchronous reset mid-FLUSH
        drive(0, 6'h00, 0, 0, 0, 0, 1);
        cycle();
        drive(0, 6'h00, 0, 0, 0, 0, 0);
        check("pre_rst.b.busy", 32'(b_busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst.b.busy",       32'(b_busy), 32'd0);
        check("async_rst.b.ifid_flush", 32'(b_iff),  32'd0);
        check("async_rst.b.pc_write",   32'(b_pc),   32'd1);
        check("async_rst.a.stall_cnt",  32'(a_sc),   32'd0);
        check("async_rst.b.flush_cnt",  32'(b_fc),   32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Saturation: hazard held for 20 stall cycles
        drive(1, 6'h03, 4, 0, 1, 4, 0);
        for (int k = 0; k < 20; k++) cycle();
        idle(1);
        check("sat.b.stall_cnt", 32'(b_sc), 32'd15);
        check("sat.a.stall_cnt", 32'(a_sc), 32'd20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
